ring_shift_counter: RTL and testbench

Parametrised one-hot ring / Johnson shift counter with selectable direction, parallel load, a period-wrap pulse and illegal-state self-correction. It is the next generation of the team's fixed-width ring counter. It serves as a phase/sequence generator for multiplexed-channel scan and strobe logic, where a corrupted pattern must recover by itself instead of circulating forever.

---
 rtl/ring_shift_counter_pkg.sv | 19 +
 rtl/ring_state_check.sv | 28 ++
 rtl/ring_shift_counter.sv | 100 ++++++++++
 tb/tb_ring_shift_counter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ring_shift_counter_pkg.sv
// ring_counter_pkg
//   Constants and helpers shared by the ring/Johnson shift counter slice.
//   MODE_*    : encoding of the mode input (ring or Johnson)
//   DIR_*     : encoding of the dir input (shift toward LSB or MSB)
//   ring_period(): number of steps in one full period for a mode/width
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  // A one-hot ring visits WIDTH states; a Johnson counter visits 2*WIDTH.
  function automatic int ring_period(input logic m, input int w);
    return (m == MODE_JOHNSON) ? 2 * w : w;
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// ring_state_check
//   Combinational legality test of a counter pattern.
//   count : current counter pattern (WIDTH bits)
//   mode  : MODE_RING or MODE_JOHNSON
//   legal : 1 when count is one of the states reachable in that mode
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  output logic             legal
);

  // Bit i set where count[i] != count[i+1]; a Johnson state has at most
  // one such boundary (all-0, all-1, or a single run of ones at one end).
  logic [WIDTH-2:0] edges;

  assign edges = count[WIDTH-1:1] ^ count[WIDTH-2:0];

  always_comb begin
    legal = 1'b0;
    if (mode == MODE_JOHNSON) legal = ($countones(edges) <= 1);
    else                      legal = ($countones(count) == 1);
  end

endmodule

// File: rtl/ring_shift_counter.sv
// ring_shift_counter
//   One-hot ring / Johnson shift counter with direction select, parallel
//   load, period-wrap pulse and self-correction of illegal patterns.
//   clk, reset : clock and synchronous active-high reset
//   en         : advance one step
//   mode       : 0 ring, 1 Johnson
//   dir        : 0 shift toward LSB, 1 shift toward MSB
//   load       : write load_val into count (unchecked)
//   load_val   : parallel load value
//   count      : registered counter state
//   wrap       : one-cycle pulse when a full period completes
//   err        : one-cycle pulse when an illegal state was replaced by SEED
module ring_shift_counter
  import ring_counter_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

  localparam int PW = $clog2(2 * WIDTH);

  logic [PW-1:0]    phase;
  logic [PW-1:0]    last_ph;
  logic             mode_q;
  logic             mode_chg;
  logic             legal;
  logic             fb;
  logic [WIDTH-1:0] nxt;

  // Legality is judged against the mode the pattern was produced under,
  // so a pattern that was valid before a mode switch still takes its one
  // shift under the new rule; any resulting illegal pattern is caught on
  // the following step.
  ring_state_check #(.WIDTH(WIDTH)) u_chk (
    .count (count),
    .mode  (mode_q),
    .legal (legal)
  );

  assign mode_chg = (mode != mode_q);
  assign last_ph  = PW'(ring_period(mode, WIDTH) - 1);

  always_comb begin
    fb = (dir == DIR_MSB) ? count[WIDTH-1] : count[0];
    if (mode == MODE_JOHNSON) fb = ~fb;
    nxt = (dir == DIR_MSB) ? {count[WIDTH-2:0], fb} : {fb, count[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    mode_q <= mode;
    if (reset) begin
      count <= SEED;
      phase <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      phase <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (en) begin
      if (!legal) begin
        count <= SEED;
        phase <= '0;
        wrap  <= 1'b0;
        err   <= 1'b1;
      end else begin
        count <= nxt;
        err   <= 1'b0;
        if (mode_chg) begin
          // Period restarts from the pattern present at the switch.
          phase <= '0;
          wrap  <= 1'b0;
        end else if (phase >= last_ph) begin
          phase <= '0;
          wrap  <= 1'b1;
        end else begin
          phase <= phase + PW'(1);
          wrap  <= 1'b0;
        end
      end
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (mode_chg) phase <= '0;
    end
  end

endmodule

// File: tb/tb_ring_shift_counter.sv
module tb_ring_shift_counter;

  logic       clk = 1'b0;
  logic       reset, en, mode, dir, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       wrap, err;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [3:0] c;
    logic       w;
    logic       e;
  } exp_t;

  exp_t sb[$];
  exp_t x;

  ring_shift_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic cyc(input string tag, input logic r, input logic ld, input logic [3:0] lv,
                     input logic e, input logic m, input logic d,
                     input logic [3:0] ec, input logic ew, input logic ee);
    exp_t t;
    @(negedge clk);
    reset = r; load = ld; load_val = lv; en = e; mode = m; dir = d;
    t.tag = tag; t.c = ec; t.w = ew; t.e = ee;
    sb.push_back(t);
  endtask

  // Scoreboard side: pop and compare just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({x.tag, ".count"}, 32'(count), 32'(x.c));
      check({x.tag, ".wrap"},  32'(wrap),  32'(x.w));
      check({x.tag, ".err"},   32'(err),   32'(x.e));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; mode = 1'b0; dir = 1'b0;

    // Ring rotation toward LSB, wrap every 4 steps
    cyc("r_rst", 1, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);
    cyc("r1",    0, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
    cyc("r2",    0, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
    cyc("r3",    0, 0, 4'h0, 1, 0, 0, 4'b0010, 0, 0);
    cyc("r4",    0, 0, 4'h0, 1, 0, 0, 4'b0001, 1, 0);
    cyc("r5",    0, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
    cyc("r6",    0, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
    cyc("r7",    0, 0, 4'h0, 1, 0, 0, 4'b0010, 0, 0);
    cyc("r8",    0, 0, 4'h0, 1, 0, 0, 4'b0001, 1, 0);

    // en gaps delay the wrap until the 4th enabled step
    cyc("g1",    0, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
    cyc("g0a",   0, 0, 4'h0, 0, 0, 0, 4'b1000, 0, 0);
    cyc("g0b",   0, 0, 4'h0, 0, 0, 0, 4'b1000, 0, 0);
    cyc("g2",    0, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
    cyc("g3",    0, 0, 4'h0, 1, 0, 0, 4'b0010, 0, 0);
    cyc("g4",    0, 0, 4'h0, 1, 0, 0, 4'b0001, 1, 0);

    // Ring toward MSB
    cyc("m_rst", 1, 0, 4'h0, 0, 0, 1, 4'b0001, 0, 0);
    cyc("m1",    0, 0, 4'h0, 1, 0, 1, 4'b0010, 0, 0);
    cyc("m2",    0, 0, 4'h0, 1, 0, 1, 4'b0100, 0, 0);

    // Johnson toward LSB, full 8-state period
    cyc("j_rst", 1, 0, 4'h0, 0, 1, 0, 4'b0001, 0, 0);
    cyc("j1",    0, 0, 4'h0, 1, 1, 0, 4'b0000, 0, 0);
    cyc("j2",    0, 0, 4'h0, 1, 1, 0, 4'b1000, 0, 0);
    cyc("j3",    0, 0, 4'h0, 1, 1, 0, 4'b1100, 0, 0);
    cyc("j4",    0, 0, 4'h0, 1, 1, 0, 4'b1110, 0, 0);
    cyc("j5",    0, 0, 4'h0, 1, 1, 0, 4'b1111, 0, 0);
    cyc("j6",    0, 0, 4'h0, 1, 1, 0, 4'b0111, 0, 0);
    cyc("j7",    0, 0, 4'h0, 1, 1, 0, 4'b0011, 0, 0);
    cyc("j8",    0, 0, 4'h0, 1, 1, 0, 4'b0001, 1, 0);
    cyc("jm_rst",1, 0, 4'h0, 0, 1, 1, 4'b0001, 0, 0);
    cyc("jm1",   0, 0, 4'h0, 1, 1, 1, 4'b0011, 0, 0);

    // Illegal loads and self-correction
    cyc("il_rst",1, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);
    cyc("il_ld", 0, 1, 4'h6, 0, 0, 0, 4'b0110, 0, 0);
    cyc("il_hld",0, 0, 4'h0, 0, 0, 0, 4'b0110, 0, 0);
    cyc("il_fix",0, 0, 4'h0, 1, 0, 0, 4'b0001, 0, 1);
    cyc("il_nx", 0, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
    cyc("ij_rst",1, 0, 4'h0, 0, 1, 0, 4'b0001, 0, 0);
    cyc("ij_ld", 0, 1, 4'h5, 0, 1, 0, 4'b0101, 0, 0);
    cyc("ij_fix",0, 0, 4'h0, 1, 1, 0, 4'b0001, 0, 1);
    cyc("ij_ok", 0, 1, 4'h3, 0, 1, 0, 4'b0011, 0, 0);
    cyc("ij_st", 0, 0, 4'h0, 1, 1, 0, 4'b0001, 0, 0);

    // Reset mid-period restarts the period
    cyc("rp_rst",1, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);
    cyc("rp1",   0, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
    cyc("rp2",   0, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
    cyc("rp_mid",1, 0, 4'h0, 1, 0, 0, 4'b0001, 0, 0);
    cyc("rp3",   0, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
    cyc("rp4",   0, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
    cyc("rp5",   0, 0, 4'h0, 1, 0, 0, 4'b0010, 0, 0);
    cyc("rp6",   0, 0, 4'h0, 1, 0, 0, 4'b0001, 1, 0);

    // Load beats en; period counted from the load
    cyc("le_ld", 0, 1, 4'h2, 1, 0, 0, 4'b0010, 0, 0);
    cyc("le1",   0, 0, 4'h0, 1, 0, 0, 4'b0001, 0, 0);
    cyc("le2",   0, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
    cyc("le3",   0, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
    cyc("le4",   0, 0, 4'h0, 1, 0, 0, 4'b0010, 1, 0);

    // Ring -> Johnson switch at 0100
    cyc("ms_rst",1, 0, 4'h0, 0, 0, 0, 4'b0001, 0, 0);
    cyc("ms1",   0, 0, 4'h0, 1, 0, 0, 4'b1000, 0, 0);
    cyc("ms2",   0, 0, 4'h0, 1, 0, 0, 4'b0100, 0, 0);
    cyc("ms_sw", 0, 0, 4'h0, 1, 1, 0, 4'b1010, 0, 0);
    cyc("ms_fix",0, 0, 4'h0, 1, 1, 0, 4'b0001, 0, 1);
    cyc("ms_nx", 0, 0, 4'h0, 1, 1, 0, 4'b0000, 0, 0);

    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
